// File: rtl/dcache_sram_arbiter.sv
// Arbiter sharing the single-ported dcache SRAM bank among its requesters:
// fixed priority with starvation aging, locked bursts and a registered read-valid strobe.
module dcache_sram_arbiter #(
  parameter int unsigned NR_PORTS  = 5,
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned BE_W      = 64,
  parameter int unsigned SET_ASSOC = 8,
  parameter int unsigned MAX_WAIT  = 15
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NR_PORTS*SET_ASSOC-1:0] req_i,
  input  logic [NR_PORTS-1:0]           lock_i,
  input  logic [NR_PORTS-1:0]           we_i,
  input  logic [NR_PORTS*ADDR_W-1:0]    addr_i,
  input  logic [NR_PORTS*DATA_W-1:0]    wdata_i,
  input  logic [NR_PORTS*BE_W-1:0]      be_i,
  output logic [NR_PORTS-1:0]           gnt_o,
  output logic [NR_PORTS-1:0]           rvalid_o,
  output logic [SET_ASSOC-1:0]          ram_req_o,
  output logic                          ram_we_o,
  output logic [ADDR_W-1:0]             ram_addr_o,
  output logic [DATA_W-1:0]             ram_wdata_o,
  output logic [BE_W-1:0]               ram_be_o,
  output logic [NR_PORTS-1:0]           starved_o
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IDX_W-1:0] idx_t;

  logic [NR_PORTS-1:0] active;
  logic [NR_PORTS-1:0] starved;
  cnt_t                age_q [NR_PORTS];
  idx_t                owner_q;
  logic                owner_vld_q;
  logic                lock_hit;
  logic                starve_hit;
  idx_t                win_idx;
  logic                win_vld;

  always_comb begin
    active  = '0;
    starved = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      active[p]  = |req_i[p*SET_ASSOC +: SET_ASSOC];
      starved[p] = (p != 0) && (age_q[p] == cnt_t'(MAX_WAIT));
    end
  end

  assign starved_o = starved;

  // Lock beats starvation, starvation beats static priority; lowest index wins ties.
  always_comb begin
    win_idx    = '0;
    win_vld    = 1'b0;
    lock_hit   = owner_vld_q && (int'(owner_q) < int'(NR_PORTS)) && active[owner_q];
    starve_hit = 1'b0;
    if (lock_hit) begin
      win_idx = owner_q;
      win_vld = 1'b1;
    end else begin
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        if (!starve_hit && active[p] && starved[p]) begin
          win_idx    = idx_t'(p);
          starve_hit = 1'b1;
        end
      end
      win_vld = starve_hit;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        if (!win_vld && active[p]) begin
          win_idx = idx_t'(p);
          win_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_o = '0;
    for (int unsigned p = 0; p < NR_PORTS; p++) begin
      gnt_o[p] = win_vld && (win_idx == idx_t'(p));
    end
  end

  // With no winner win_idx is 0, so the data-side mux presents port 0.
  assign ram_req_o   = win_vld ? req_i[win_idx*SET_ASSOC +: SET_ASSOC] : '0;
  assign ram_we_o    = win_vld & we_i[win_idx];
  assign ram_addr_o  = addr_i[win_idx*ADDR_W +: ADDR_W];
  assign ram_wdata_o = wdata_i[win_idx*DATA_W +: DATA_W];
  assign ram_be_o    = be_i[win_idx*BE_W +: BE_W];

  // Owner re-arms on every granted cycle, so dropping req or lock releases it next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
    end else begin
      owner_q     <= win_idx;
      owner_vld_q <= win_vld & lock_i[win_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        age_q[p] <= '0;
      end
    end else begin
      rvalid_o <= gnt_o & ~we_i;
      for (int unsigned p = 0; p < NR_PORTS; p++) begin
        if (p == 0 || !active[p] || gnt_o[p]) begin
          age_q[p] <= '0;
        end else if (age_q[p] != cnt_t'(MAX_WAIT)) begin
          age_q[p] <= age_q[p] + cnt_t'(1);
        end
      end
    end
  end

endmodule
